// File: rtl/code_conv_arbiter_pkg.sv
// Shared constants, FSM encoding and conversion helpers for the code-conversion arbiter.
package code_conv_arbiter_pkg;

    localparam int unsigned MODE_W = 3;
    localparam int unsigned DATA_W = 4;
    localparam int unsigned RES_W  = 8;

    localparam logic [MODE_W-1:0] MODE_B2G   = 3'd0;
    localparam logic [MODE_W-1:0] MODE_G2B   = 3'd1;
    localparam logic [MODE_W-1:0] MODE_B2BCD = 3'd2;
    localparam logic [MODE_W-1:0] MODE_G2BCD = 3'd3;
    localparam logic [MODE_W-1:0] MODE_B2E3  = 3'd4;
    localparam logic [MODE_W-1:0] MODE_E32B  = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CONVERT = 2'd1,
        ST_RESP    = 2'd2
    } state_t;

    // Gray to binary: each binary bit is the xor of all gray bits at or above it.
    function automatic logic [DATA_W-1:0] gray_to_bin(input logic [DATA_W-1:0] g);
        logic [DATA_W-1:0] b;
        b[3] = g[3];
        b[2] = b[3] ^ g[2];
        b[1] = b[2] ^ g[1];
        b[0] = b[1] ^ g[0];
        return b;
    endfunction

    // Two-digit BCD of a 4-bit value (0..15).
    function automatic logic [RES_W-1:0] bin_to_bcd(input logic [DATA_W-1:0] b);
        if (b >= 4'd10) begin
            return {4'd1, b - 4'd10};
        end
        return {4'd0, b};
    endfunction

endpackage

// File: rtl/code_conv_arbiter_conv_core.sv
// Combinational universal 4-bit code converter; result forced to zero on error.
module conv_core
    import code_conv_arbiter_pkg::*;
(
    input  logic [MODE_W-1:0] mode,
    input  logic [DATA_W-1:0] d,
    output logic [RES_W-1:0]  res,
    output logic              err
);

    // Mode decode and conversion.
    always_comb begin
        res = '0;
        err = 1'b0;
        case (mode)
            MODE_B2G:   res = {4'b0, d ^ (d >> 1)};
            MODE_G2B:   res = {4'b0, gray_to_bin(d)};
            MODE_B2BCD: res = bin_to_bcd(d);
            MODE_G2BCD: res = bin_to_bcd(gray_to_bin(d));
            MODE_B2E3: begin
                if (d > 4'd9) err = 1'b1;
                else          res = {4'b0, d + 4'd3};
            end
            MODE_E32B: begin
                if ((d < 4'd3) || (d > 4'd12)) err = 1'b1;
                else                           res = {4'b0, d - 4'd3};
            end
            default:    err = 1'b1;
        endcase
    end

endmodule

// File: rtl/code_conv_arbiter.sv
// Round-robin front end sharing one conv_core between NREQ requesters.
module code_conv_arbiter
    import code_conv_arbiter_pkg::*;
#(
    parameter int unsigned NREQ = 4,
    parameter int unsigned CNTW = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREQ-1:0]           req_valid,
    input  logic [3*NREQ-1:0]         req_mode,
    input  logic [4*NREQ-1:0]         req_data,
    output logic [NREQ-1:0]           req_ack,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [RES_W-1:0]          out_data,
    output logic [$clog2(NREQ)-1:0]   out_id,
    output logic                      out_err,
    output logic                      busy,
    output logic [CNTW-1:0]           done_cnt
);

    localparam int unsigned IDW = $clog2(NREQ);

    state_t            state;
    state_t            next_state;
    logic [IDW-1:0]    rr_ptr;
    logic [IDW-1:0]    lat_id;
    logic [MODE_W-1:0] lat_mode;
    logic [DATA_W-1:0] lat_data;

    logic              any_req_c;
    logic [IDW-1:0]    win_id_c;
    logic [MODE_W-1:0] win_mode_c;
    logic [DATA_W-1:0] win_data_c;
    logic              load_c;
    logic              capture_c;
    logic              release_c;
    logic [RES_W-1:0]  core_res;
    logic              core_err;

    conv_core u_conv_core (
        .mode (lat_mode),
        .d    (lat_data),
        .res  (core_res),
        .err  (core_err)
    );

    // Round-robin pick: first valid requester at or after rr_ptr, with wrap.
    always_comb begin
        int unsigned idx;
        any_req_c = 1'b0;
        win_id_c  = rr_ptr;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = 32'(rr_ptr) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (!any_req_c && req_valid[IDW'(idx)]) begin
                any_req_c = 1'b1;
                win_id_c  = IDW'(idx);
            end
        end
    end

    // Operand mux for the selected requester.
    always_comb begin
        win_mode_c = '0;
        win_data_c = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (IDW'(i) == win_id_c) begin
                win_mode_c = req_mode[3*i +: 3];
                win_data_c = req_data[4*i +: 4];
            end
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= next_state;
    end

    // Next-state logic; IDLE is the only state that looks at requests.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:    if (any_req_c) next_state = ST_CONVERT;
            ST_CONVERT: next_state = ST_RESP;
            ST_RESP:    if (out_valid && out_ready) next_state = ST_IDLE;
            default:    next_state = ST_IDLE;
        endcase
    end

    // Per-state control strobes for the datapath registers.
    always_comb begin
        load_c    = 1'b0;
        capture_c = 1'b0;
        release_c = 1'b0;
        case (state)
            ST_IDLE:    load_c    = any_req_c;
            ST_CONVERT: capture_c = 1'b1;
            ST_RESP:    release_c = out_valid && out_ready;
            default:    ;
        endcase
    end

    // Operand latch, ack pulse, result register, pointer and counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr    <= '0;
            lat_id    <= '0;
            lat_mode  <= '0;
            lat_data  <= '0;
            req_ack   <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_id    <= '0;
            out_err   <= 1'b0;
            busy      <= 1'b0;
            done_cnt  <= '0;
        end else begin
            busy    <= (next_state != ST_IDLE);
            req_ack <= '0;
            if (load_c) begin
                lat_id   <= win_id_c;
                lat_mode <= win_mode_c;
                lat_data <= win_data_c;
                req_ack  <= NREQ'(1) << win_id_c;
            end
            if (capture_c) begin
                out_valid <= 1'b1;
                out_data  <= core_res;
                out_err   <= core_err;
                out_id    <= lat_id;
            end
            if (release_c) begin
                out_valid <= 1'b0;
                rr_ptr    <= (lat_id == IDW'(NREQ - 1)) ? '0 : lat_id + IDW'(1);
                done_cnt  <= done_cnt + CNTW'(1);
            end
        end
    end

endmodule

// File: tb/tb_code_conv_arbiter.sv
// Self-checking bench for code_conv_arbiter: directed plan steps plus randomized traffic.
module tb_code_conv_arbiter;

    localparam int NREQ = 4;
    localparam int CNTW = 16;

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic [NREQ-1:0]     req_valid = '0;
    logic [3*NREQ-1:0]   req_mode = '0;
    logic [4*NREQ-1:0]   req_data = '0;
    logic [NREQ-1:0]     req_ack;
    logic                out_valid;
    logic                out_ready = 1'b0;
    logic [7:0]          out_data;
    logic [1:0]          out_id;
    logic                out_err;
    logic                busy;
    logic [CNTW-1:0]     done_cnt;

    int checks = 0;
    int failures = 0;

    // Requester-side view and reference state.
    bit v [NREQ];
    int m [NREQ];
    int dd[NREQ];
    int ptr = 0;
    int cnt = 0;

    code_conv_arbiter #(.NREQ(NREQ), .CNTW(CNTW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_mode  (req_mode),
        .req_data  (req_data),
        .req_ack   (req_ack),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_id    (out_id),
        .out_err   (out_err),
        .busy      (busy),
        .done_cnt  (done_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference conversion: returns {err, data}.
    function automatic logic [8:0] model_conv(input int mode, input int d);
        int b;
        case (mode)
            0: return {1'b0, 8'(d ^ (d / 2))};
            1: return {1'b0, 8'(d ^ (d / 2) ^ (d / 4) ^ (d / 8))};
            2: return {1'b0, 8'((d / 10) * 16 + d % 10)};
            3: begin
                b = d ^ (d / 2) ^ (d / 4) ^ (d / 8);
                return {1'b0, 8'((b / 10) * 16 + b % 10)};
            end
            4: return (d > 9) ? 9'h100 : {1'b0, 8'(d + 3)};
            5: return (d < 3 || d > 12) ? 9'h100 : {1'b0, 8'(d - 3)};
            default: return 9'h100;
        endcase
    endfunction

    // Reference arbitration: first valid requester from p upward, wrapping.
    function automatic int model_arb(input int p);
        for (int k = 0; k < NREQ; k++) begin
            if (v[(p + k) % NREQ]) return (p + k) % NREQ;
        end
        return -1;
    endfunction

    task automatic drive();
        for (int i = 0; i < NREQ; i++) begin
            req_valid[i]       = v[i];
            req_mode[3*i +: 3] = 3'(m[i]);
            req_data[4*i +: 4] = 4'(dd[i]);
        end
    endtask

    task automatic set_req(input int i, input bit val, input int mode, input int d);
        v[i] = val; m[i] = mode; dd[i] = d;
        drive();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        check("rst_ack", req_ack, 0);
        check("rst_valid", out_valid, 0);
        check("rst_data", out_data, 0);
        check("rst_id", out_id, 0);
        check("rst_err", out_err, 0);
        check("rst_busy", busy, 0);
        check("rst_cnt", done_cnt, 0);
        rst = 1'b0;
        ptr = 0;
        cnt = 0;
    endtask

    // Wait (bounded) for the CONVERT-cycle ack; returns the expected winner, or -1.
    task automatic wait_ack(output int w);
        bit got = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (req_ack != '0) begin got = 1; break; end
        end
        check("ack_seen", 32'(got), 1);
        w = -1;
        if (got) begin
            w = model_arb(ptr);
            check("ack_onehot", req_ack, (w < 0) ? 0 : (1 << w));
            check("busy_convert", busy, 1);
        end
    endtask

    // One full transaction. policy: 0 drop after ack, 1 hold, 2 re-randomize.
    task automatic do_txn(input int stall, input int policy);
        int w;
        logic [8:0] r;
        wait_ack(w);
        if (w < 0) return;
        r = model_conv(m[w], dd[w]);
        if (policy == 0) set_req(w, 0, m[w], dd[w]);
        if (policy == 2) set_req(w, 1'($urandom_range(0, 1)), $urandom_range(0, 7), $urandom_range(0, 15));
        out_ready = (stall == 0);
        @(negedge clk);
        check("resp_valid", out_valid, 1);
        check("resp_data", out_data, r[7:0]);
        check("resp_id", out_id, w);
        check("resp_err", out_err, r[8]);
        check("resp_noack", req_ack, 0);
        for (int s = 1; s < stall; s++) begin
            @(negedge clk);
            check("stall_valid", out_valid, 1);
            check("stall_data", out_data, r[7:0]);
            check("stall_id", out_id, w);
            check("stall_noack", req_ack, 0);
            check("stall_busy", busy, 1);
        end
        out_ready = 1'b1;
        @(negedge clk);
        ptr = (w + 1) % NREQ;
        cnt = (cnt + 1) % (1 << CNTW);
        check("rel_valid", out_valid, 0);
        check("rel_busy", busy, 0);
        check("rel_cnt", done_cnt, cnt);
    endtask

    initial begin
        int w;
        for (int i = 0; i < NREQ; i++) begin v[i] = 0; m[i] = 0; dd[i] = 0; end
        drive();
        do_reset();

        // Single requester, gray->bcd of 4'b1011.
        set_req(0, 1, 3, 11);
        do_txn(0, 0);

        // All four from the first cycle after reset: grants 0,1,2,3.
        do_reset();
        set_req(0, 1, 0, 5); set_req(1, 1, 1, 5); set_req(2, 1, 2, 9); set_req(3, 1, 4, 9);
        for (int k = 0; k < 4; k++) do_txn(0, 0);

        // Requesters 1 and 3 held continuously: alternate 1,3,1,3.
        set_req(1, 1, 2, 13); set_req(3, 1, 0, 6);
        for (int k = 0; k < 4; k++) do_txn(0, 1);
        set_req(1, 0, 0, 0); set_req(3, 0, 0, 0);

        // Error cases.
        set_req(0, 1, 5, 2);  do_txn(0, 0);
        set_req(0, 1, 4, 10); do_txn(0, 0);
        set_req(0, 1, 7, 3);  do_txn(0, 0);
        set_req(0, 1, 5, 13); do_txn(0, 0);
        set_req(0, 1, 4, 9);  do_txn(0, 0);

        // Five-cycle stall with another requester waiting.
        set_req(2, 1, 1, 9); set_req(3, 1, 2, 14);
        do_txn(5, 0);
        do_txn(0, 0);

        // Reset during RESP: pointer returns to 0, in-flight result discarded.
        set_req(0, 1, 0, 3); do_txn(0, 0);
        set_req(0, 1, 2, 12); set_req(2, 1, 3, 7);
        wait_ack(w);
        check("pre_rst_winner", w, 2);
        out_ready = 1'b0;
        @(negedge clk);
        check("pre_rst_valid", out_valid, 1);
        do_reset();
        do_txn(2, 0);
        do_txn(0, 0);

        // Randomized traffic.
        for (int n = 0; n < 40; n++) begin
            if (model_arb(0) < 0) begin
                w = $urandom_range(0, NREQ - 1);
                set_req(w, 1, $urandom_range(0, 7), $urandom_range(0, 15));
            end
            do_txn($urandom_range(0, 3), 2);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/code_conv_arbiter.md
Name: code_conv_arbiter

Overview:
- Sequential front end that shares one combinational universal code-conversion datapath between NREQ requesters.
- Each requester presents a 4-bit code and a conversion mode.
- Block arbitrates round-robin, latches the winner's operands, runs the datapath, registers the result, and holds it on a valid/ready output until consumed.
- Sits between per-channel input logic (switch/keypad decoders) and the shared display/output stage.

Parameters:
- NREQ, 4, number of requesters (2..8).
- CNTW, 16, width of completed-transaction counter.

Ports:
- clk  input  1  system clock, all logic rising-edge.
- rst  input  1  synchronous, active-high reset.
- req_valid  input  NREQ  per-requester request; held high with mode/data stable until matching req_ack.
- req_mode  input  3*NREQ  per-requester mode; requester i uses bits [3i+2:3i].
- req_data  input  4*NREQ  per-requester 4-bit input code; requester i uses bits [4i+3:4i].
- req_ack  output  NREQ  one-hot, one-cycle pulse: request captured.
- out_valid  output  1  result available.
- out_ready  input  1  consumer accepts result.
- out_data  output  8  converted result.
- out_id  output  $clog2(NREQ)  index of requester owning out_data.
- out_err  output  1  invalid mode or input code for the mode.
- busy  output  1  high whenever state != IDLE.
- done_cnt  output  CNTW  count of completed output handshakes; wraps.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high (rst).
- Reset (rst high at a clock edge) forces:
  - state = IDLE, rr_ptr = 0;
  - req_ack = 0, out_valid = 0, out_data = 0, out_id = 0, out_err = 0, busy = 0, done_cnt = 0.
- Reset wins over every other event, including mid-CONVERT and mid-RESP. Any in-flight result is discarded and no ack is reissued.
- FSM states: IDLE, CONVERT, RESP.
- IDLE:
  - If any req_valid is high, select the first set bit scanning upward from rr_ptr with wrap (NREQ-1 wraps to 0).
  - Latch mode, data and id of the winner; go to CONVERT.
  - No request: stay in IDLE.
- CONVERT, exactly one cycle:
  - req_ack[id] = 1 for this cycle only.
  - conv_core evaluates the latched operands; out_data, out_err and out_id are registered at the end of the cycle.
  - out_valid = 1 from the next cycle; go to RESP.
- RESP:
  - out_valid, out_data, out_id and out_err are held stable while out_ready is low, with no limit on the stall.
  - On out_valid && out_ready: out_valid = 0 next cycle, rr_ptr = (id+1) mod NREQ, done_cnt += 1 (wraps at 2^CNTW), go to IDLE.
- Timing:
  - Latency: request sampled in IDLE at cycle t; req_ack high at t+1; out_valid high at t+2.
  - Peak throughput: one transaction per 3 cycles with out_ready tied high.
- Requester rules:
  - A requester drops or changes req_valid only after seeing req_ack.
  - A still-high req_valid in the IDLE cycle after RESP is treated as a new request.
  - req_valid dropping before ack is legal: that requester simply is not selected.
- Mode encoding, with conv_core results (data d):
  - 0 bin->gray: out = {4'b0, d ^ (d>>1)}.
  - 1 gray->bin: out = {4'b0, b}, where b3 = g3 and bi = b(i+1) ^ gi.
  - 2 bin->bcd: out = {tens, units} of d (0..15, e.g. 13 -> 8'h13).
  - 3 gray->bcd: gray->bin, then bin->bcd.
  - 4 bin->excess3: out = d+3; err if d > 9.
  - 5 excess3->bin: out = d-3; err if d < 3 or d > 12.
  - 6, 7: err = 1.
- Whenever err = 1, out_data = 8'h00. Erroneous results still complete the handshake and increment done_cnt.
- No simultaneous grant and release: IDLE is the only state that samples requests.

Decomposition:
- Shared package: mode constants (MODE_B2G=0 ... MODE_E32B=5), FSM state encoding, result width 8.
- Sub-module conv_core: combinational; inputs mode[2:0] and d[3:0]; outputs res[7:0] and err. Reused by other converter tops.
- Arbiter pointer and FSM stay in code_conv_arbiter.

Test Plan:
- Reset, then requester 0 only, mode 3, data 4'b1011 -> req_ack = 4'b0001 at t+1; out_valid at t+2 with out_data = 8'h13, out_id = 0, out_err = 0; done_cnt = 1 after handshake.
- All four requesters valid from first cycle after reset, out_ready = 1, modes 0/1/2/4 with data 5/5/9/9:
  - grant order 0,1,2,3;
  - out_data 8'h07, 8'h06, 8'h09, 8'h0C;
  - done_cnt = 4.
- Requesters 1 and 3 hold valid continuously (re-asserting after ack) -> grants alternate 1,3,1,3; rr_ptr wraps correctly, and requester 1 is never starved.
- Error cases, each completing normally with done_cnt incrementing:
  - mode 5, data 4'h2 -> out_err = 1, out_data = 8'h00;
  - mode 4, data 4'hA -> out_err = 1;
  - mode 7 -> out_err = 1.
- out_ready low for 5 cycles in RESP -> out_valid/out_data/out_id constant all 5 cycles; no new req_ack; release on out_ready = 1 -> IDLE next cycle.
- rst asserted during RESP with out_ready low -> next cycle all outputs 0 and state IDLE; pending requester re-arbitrated from rr_ptr = 0; done_cnt = 0.
